// File: rtl/mem_responder_if.sv
// Datapath-to-memory handshake bundle: MAR/MDR request side plus read data and status.
// The master is the CPU datapath; the slave is the memory responder.
interface mem_responder_if;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic        Read;
    logic        Write;
    logic [31:0] Mdatain;
    logic        Done;
    logic        Busy;
    logic        Err;

    modport master (
        output Address, DataIn, Read, Write,
        input  Mdatain, Done, Busy, Err
    );

    modport slave (
        input  Address, DataIn, Read, Write,
        output Mdatain, Done, Busy, Err
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed 32-bit memory responder with programmable wait states and a
// four-phase Read/Write -> Done handshake towards the CPU datapath.
module mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            clr,
    mem_responder_if.slave  bus
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_responder: WAIT_CYCLES must be within 0..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t              state, state_n;
    logic [3:0]          cnt;
    logic                op_rd;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         data_q;
    logic [31:0]         mdatain_q;
    logic                done_q;
    logic                err_q;

    logic                latch_req;
    logic                cnt_dec;
    logic                do_access;
    logic                do_release;
    logic                mem_we;

    logic [31:0]         mem [2**ADDR_W];

    // Upper address bits are deliberately dropped so addresses alias.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.Address[31:ADDR_W];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n    = state;
        latch_req  = 1'b0;
        cnt_dec    = 1'b0;
        do_access  = 1'b0;
        do_release = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.Read || bus.Write) begin
                    latch_req = 1'b1;
                    state_n   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_dec = 1'b1;
                end else begin
                    do_access = 1'b1;
                    state_n   = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!bus.Read && !bus.Write) begin
                    do_release = 1'b1;
                    state_n    = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign mem_we = do_access && !op_rd;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            op_rd     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            mdatain_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_n;
            if (latch_req) begin
                // Read wins a simultaneous request; the clash is recorded until reset.
                op_rd  <= bus.Read;
                addr_q <= bus.Address[ADDR_W-1:0];
                data_q <= bus.DataIn;
                cnt    <= 4'(WAIT_CYCLES);
                err_q  <= err_q | (bus.Read & bus.Write);
            end
            if (cnt_dec) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                done_q <= 1'b1;
                if (op_rd) begin
                    mdatain_q <= mem[addr_q];
                end
            end
            if (do_release) begin
                done_q <= 1'b0;
            end
        end
    end

    // NOTE: the array has no reset; clr holds the FSM in IDLE, which keeps mem_we low.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= data_q;
        end
    end

    assign bus.Mdatain = mdatain_q;
    assign bus.Done    = done_q;
    assign bus.Busy    = (state != S_IDLE);
    assign bus.Err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances cover WAIT_CYCLES of 2, 0 and 4
// and share one clock and one clr.
module tb_mem_responder;

    logic clk;
    logic clr;

    // Unit index: 0 -> WAIT_CYCLES=2, 1 -> WAIT_CYCLES=0, 2 -> WAIT_CYCLES=4.
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [31:0] addr [3];
    logic [31:0] din  [3];
    logic [31:0] mdat [3];
    logic [2:0]  done_v;
    logic [2:0]  busy_v;
    logic [2:0]  err_v;

    int n_cmp;
    int n_bad;

    mem_responder_if bus_w2 ();
    mem_responder_if bus_w0 ();
    mem_responder_if bus_w4 ();

    mem_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) dut_w2 (.clk(clk), .clr(clr), .bus(bus_w2.slave));
    mem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) dut_w0 (.clk(clk), .clr(clr), .bus(bus_w0.slave));
    mem_responder #(.ADDR_W(9), .WAIT_CYCLES(4)) dut_w4 (.clk(clk), .clr(clr), .bus(bus_w4.slave));

    assign bus_w2.Read = rd[0];  assign bus_w2.Write = wr[0];
    assign bus_w2.Address = addr[0];  assign bus_w2.DataIn = din[0];
    assign bus_w0.Read = rd[1];  assign bus_w0.Write = wr[1];
    assign bus_w0.Address = addr[1];  assign bus_w0.DataIn = din[1];
    assign bus_w4.Read = rd[2];  assign bus_w4.Write = wr[2];
    assign bus_w4.Address = addr[2];  assign bus_w4.DataIn = din[2];

    assign mdat[0] = bus_w2.Mdatain;  assign done_v[0] = bus_w2.Done;
    assign busy_v[0] = bus_w2.Busy;   assign err_v[0] = bus_w2.Err;
    assign mdat[1] = bus_w0.Mdatain;  assign done_v[1] = bus_w0.Done;
    assign busy_v[1] = bus_w0.Busy;   assign err_v[1] = bus_w0.Err;
    assign mdat[2] = bus_w4.Mdatain;  assign done_v[2] = bus_w4.Done;
    assign busy_v[2] = bus_w4.Busy;   assign err_v[2] = bus_w4.Err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise a request, count edges until Done, then optionally drop the request
    // and confirm the responder returns to idle one edge later.
    task automatic access(input int u, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input int lat, input bit hold, input string tag);
        int  n;
        bit  seen;
        rd[u] = r;  wr[u] = w;  addr[u] = a;  din[u] = d;
        seen = 1'b0;
        n    = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            tick();
            if (i == 1) check({tag, "_busy_start"}, 32'(busy_v[u]), 32'd1);
            if (done_v[u]) begin
                seen = 1'b1;
                n    = i;
            end
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        if (!hold) begin
            rd[u] = 1'b0;
            wr[u] = 1'b0;
            tick();
            check({tag, "_done_fall"}, 32'(done_v[u]), 32'd0);
            check({tag, "_busy_fall"}, 32'(busy_v[u]), 32'd0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clr   = 1'b0;
        rd    = '0;
        wr    = '0;
        for (int u = 0; u < 3; u++) begin
            addr[u] = '0;
            din[u]  = '0;
        end
        tick();
        tick();
        for (int u = 0; u < 3; u++) begin
            check($sformatf("reset_mdat%0d", u), mdat[u], 32'd0);
            check($sformatf("reset_done%0d", u), 32'(done_v[u]), 32'd0);
            check($sformatf("reset_busy%0d", u), 32'(busy_v[u]), 32'd0);
            check($sformatf("reset_err%0d", u), 32'(err_v[u]), 32'd0);
        end
        clr = 1'b1;
        tick();

        // Write then read with two wait states: Done 3 edges after the sample.
        access(0, 1'b0, 1'b1, 32'h5, 32'h0000000A, 4, 1'b0, "t1_wr");
        check("t1_wr_mdat_unchanged", mdat[0], 32'd0);
        access(0, 1'b1, 1'b0, 32'h5, 32'h0, 4, 1'b0, "t1_rd");
        check("t1_rd_data", mdat[0], 32'h0000000A);
        check("t1_err", 32'(err_v[0]), 32'd0);

        // Back-to-back with no wait states; next request issued as soon as Busy drops.
        access(1, 1'b0, 1'b1, 32'h1, 32'h12, 2, 1'b0, "t2_wr1");
        access(1, 1'b0, 1'b1, 32'h2, 32'h2, 2, 1'b0, "t2_wr2");
        access(1, 1'b1, 1'b0, 32'h1, 32'h0, 2, 1'b0, "t2_rd1");
        check("t2_rd1_data", mdat[1], 32'h12);
        access(1, 1'b1, 1'b0, 32'h2, 32'h0, 2, 1'b0, "t2_rd2");
        check("t2_rd2_data", mdat[1], 32'h2);

        // Read held through RELEASE: handshake stalls, no second access.
        access(1, 1'b1, 1'b0, 32'h1, 32'h0, 2, 1'b1, "t3_rd");
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("t3_hold_done%0d", i), 32'(done_v[1]), 32'd1);
            check($sformatf("t3_hold_busy%0d", i), 32'(busy_v[1]), 32'd1);
        end
        check("t3_data", mdat[1], 32'h12);
        rd[1] = 1'b0;
        tick();
        check("t3_done_fall", 32'(done_v[1]), 32'd0);
        check("t3_busy_fall", 32'(busy_v[1]), 32'd0);

        // Simultaneous Read and Write: read wins, write dropped, Err sticks.
        access(0, 1'b0, 1'b1, 32'h3, 32'h77, 4, 1'b0, "t4_pre");
        access(0, 1'b1, 1'b1, 32'h3, 32'hFFFFFFFF, 4, 1'b0, "t4_both");
        check("t4_both_data", mdat[0], 32'h77);
        check("t4_err_set", 32'(err_v[0]), 32'd1);
        access(0, 1'b1, 1'b0, 32'h3, 32'h0, 4, 1'b0, "t4_reread");
        check("t4_reread_data", mdat[0], 32'h77);
        check("t4_err_sticky", 32'(err_v[0]), 32'd1);

        // Aliasing: 0x204 and 0x4 are the same word with ADDR_W=9.
        access(0, 1'b0, 1'b1, 32'h00000204, 32'hDEADBEEF, 4, 1'b0, "t5_wr");
        access(0, 1'b1, 1'b0, 32'h00000004, 32'h0, 4, 1'b0, "t5_rd");
        check("t5_alias_data", mdat[0], 32'hDEADBEEF);
        check("t5_err_still", 32'(err_v[0]), 32'd1);

        // Reset during the second wait cycle aborts the pending write.
        access(2, 1'b0, 1'b1, 32'h7, 32'h5555AAAA, 6, 1'b0, "t6_pre");
        access(2, 1'b1, 1'b0, 32'h7, 32'h0, 6, 1'b0, "t6_pre_rd");
        check("t6_pre_data", mdat[2], 32'h5555AAAA);
        wr[2] = 1'b1;  addr[2] = 32'h7;  din[2] = 32'h1234;
        tick();
        tick();
        clr   = 1'b0;
        wr[2] = 1'b0;
        #1;
        check("t6_clr_mdat", mdat[2], 32'd0);
        check("t6_clr_done", 32'(done_v[2]), 32'd0);
        check("t6_clr_busy", 32'(busy_v[2]), 32'd0);
        check("t6_clr_err", 32'(err_v[2]), 32'd0);
        check("t6_clr_err_w2", 32'(err_v[0]), 32'd0);
        tick();
        check("t6_clr_busy_hold", 32'(busy_v[2]), 32'd0);
        clr = 1'b1;
        tick();
        access(2, 1'b1, 1'b0, 32'h7, 32'h0, 6, 1'b0, "t6_rd");
        check("t6_rd_data", mdat[2], 32'h5555AAAA);
        check("t6_err_after", 32'(err_v[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
